uart_tx_feeder: RTL
===================

// Module: uart_tx_feeder
// PURPOSE
//  Byte FIFO and pacing controller directly upstream of the UART transmitter.
//  Accepts bytes from the host/core side at any rate up to 1 per clock and buffers them.
//  Drains them one at a time into the transmitter via a 1-cycle tx_start pulse + tx_data.
//  Paced by the transmitter's tx_busy, so back-to-back bytes go out with no gaps and no loss.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >= 2
//  ADDR_W  4   log2(DEPTH); count width is ADDR_W+1
// PORTS
//  clk       in   1         system clock; all logic on rising edge
//  rst       in   1         synchronous, active-high reset
//  wr_en     in   1         write request; byte accepted when wr_en && !full
//  wr_data   in   8         byte to enqueue
//  full      out  1         count == DEPTH
//  empty     out  1         count == 0
//  count     out  ADDR_W+1  bytes currently buffered (excludes byte handed to transmitter)
//  tx_start  out  1         1-cycle pulse to transmitter
//  tx_data   out  8         byte for transmitter; valid with tx_start, held until next pop
//  tx_busy   in   1         transmitter busy; rises the cycle after tx_start, falls after stop bit
//  ovf       out  1         sticky overflow flag (UART_TX_FEEDER_OVF_EN only)
//  ovf_clr   in   1         clears ovf (UART_TX_FEEDER_OVF_EN only)
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): rd/wr pointers=0, count=0, full=0, empty=1, tx_start=0,
//   tx_data=8'h00, ovf=0, state=IDLE; any byte in flight is abandoned, FIFO contents discarded.
//  FIFO: circular, ADDR_W-bit pointers wrap DEPTH-1 -> 0; full/empty derived from count.
//   Write when full is dropped (no pointer/count change). full is evaluated on pre-edge count,
//   so a write in the same cycle as a pop while full is still dropped.
//   Simultaneous accepted write + pop: count unchanged, both pointers advance.
//  FSM (registered outputs):
//   IDLE      : if !empty && !tx_busy -> tx_data<=mem[rd_ptr], rd_ptr++, tx_start<=1, go START.
//   START     : tx_start<=0; go WAIT_BUSY.
//   WAIT_BUSY : hold until tx_busy==1, then go WAIT_DONE (never re-pulses before busy seen).
//   WAIT_DONE : hold until tx_busy==0, then go IDLE.
//  tx_start is high for exactly one cycle per popped byte; never asserted outside IDLE->START.
//  Latency: byte written at edge N into empty FIFO with FSM in IDLE -> tx_start high after
//   edge N+1 (tx_data valid same cycle). Next byte pulse no earlier than 1 cycle after
//   tx_busy falls (IDLE re-checks).
//  Pop order strictly FIFO; a byte written at edge N is never popped at edge N.
//  count: +1 on accepted write, -1 on pop, max DEPTH, never wraps.
// CONFIGURATION
//  UART_TX_FEEDER_OVF_EN defined: ovf<=1 on any wr_en while full (incl. write+pop case);
//   stays 1 until ovf_clr=1 at an edge (clr wins over a same-cycle set).
//  Not defined: ovf driven constant 0, ovf_clr ignored; drop-when-full unchanged.
// STRUCTURE
//  Shared package uart_pkg: FSM state encodings (IDLE/START/WAIT_BUSY/WAIT_DONE, 2 bits),
//   default DEPTH constant, byte width constant 8.
//  One sub-module: uart_byte_fifo (storage, pointers, count, full/empty; sync reset).
//  FSM + tx_start/tx_data registers stay in uart_tx_feeder top.
// TESTING (bench models transmitter: tx_busy rises 1 cycle after tx_start, stays high 10 bit-times)
//  Single byte: reset, write 8'hA5 -> tx_start 1 cycle with tx_data=A5 at edge+2, count 1->0, empty.
//  Burst: write 8'h01..8'h05 back-to-back -> 5 pulses in order 01..05, each only after tx_busy fell.
//  Full: write DEPTH+3 bytes with tx_busy held 1 -> full=1, count=16, last 3 dropped, ovf=1 (OVF_EN),
//   ovf_clr clears it; without OVF_EN ovf stays 0.
//  Simultaneous: at count=16 pop + write same edge -> write dropped, count=15; at count=3 -> stays 3.
//  Reset mid-operation: rst during WAIT_DONE with 4 queued -> count=0, empty=1, tx_start=0, no pulse
//   after rst release until new write.
//  Pointer wrap: 3*DEPTH bytes with incrementing values streamed -> output sequence contiguous, no loss.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART-side definitions: byte type, default FIFO depth and the
// transmit-feeder FSM state encoding.
package uart_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with occupancy count; full/empty are derived from the
// pre-edge count, so a write while full is dropped even if a pop happens too.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  byte_t             mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after it has been written, and clearing a RAM costs a mux per bit.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus pacing FSM feeding a UART transmitter one byte per tx_busy
// cycle. Optional sticky overflow flag: define UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              ovf,
  input  logic              ovf_clr
);

  tx_state_e state_q;
  tx_state_e state_d;
  logic      tx_start_d;
  byte_t     tx_data_d;
  byte_t     fifo_rd_data;
  logic      pop;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // NOTE: every signal written here gets a default first, so no branch can
  // leave a value implicitly held and infer a latch.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          tx_data_d  = fifo_rd_data;
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      // Wait for the transmitter to acknowledge before watching for its end,
      // otherwise a slow busy rise would look like an immediate completion.
      WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all registered state, so each flop
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state_q  <= state_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  // Any write attempt while full is flagged, including one that coincides
  // with a pop; a clear in the same cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end
  end
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule
